// File: rtl/srec_pkg.sv
// Shared definitions for the S-record stream decoder.
//   state_t     : parser state encoding
//   ERR_*       : error codes reported on error_code
//   CH_*        : ASCII characters the parser recognises
//   addr_bytes(): number of address bytes carried by an S-record type char
//                 (0 means the type is not a legal S-record type)
package srec_pkg;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_TYPE,
    ST_CNT_HI,
    ST_CNT_LO,
    ST_ADDR,
    ST_DATA_HI,
    ST_DATA_LO,
    ST_CSUM_HI,
    ST_CSUM_LO,
    ST_EOL,
    ST_RESYNC
  } state_t;

  localparam logic [2:0] ERR_NONE  = 3'd0;
  localparam logic [2:0] ERR_START = 3'd1;
  localparam logic [2:0] ERR_HEX   = 3'd2;
  localparam logic [2:0] ERR_TYPE  = 3'd3;
  localparam logic [2:0] ERR_LEN   = 3'd4;
  localparam logic [2:0] ERR_CSUM  = 3'd5;
  localparam logic [2:0] ERR_EOL   = 3'd6;

  localparam logic [7:0] CH_CR    = 8'h0D;
  localparam logic [7:0] CH_LF    = 8'h0A;
  localparam logic [7:0] CH_0     = 8'h30;
  localparam logic [7:0] CH_9     = 8'h39;
  localparam logic [7:0] CH_UP_A  = 8'h41;
  localparam logic [7:0] CH_UP_F  = 8'h46;
  localparam logic [7:0] CH_LOW_A = 8'h61;
  localparam logic [7:0] CH_LOW_F = 8'h66;
  localparam logic [7:0] CH_S     = 8'h53;

  function automatic logic [2:0] addr_bytes(input logic [7:0] type_char);
    case (type_char)
      8'h30, 8'h31, 8'h35, 8'h39: addr_bytes = 3'd2;
      8'h32, 8'h36, 8'h38:        addr_bytes = 3'd3;
      8'h33, 8'h37:               addr_bytes = 3'd4;
      default:                    addr_bytes = 3'd0;
    endcase
  endfunction

endpackage

// File: rtl/srec_hex_decode.sv
// Combinational ASCII hex digit decoder.
//   char_in : ASCII character
//   nibble  : decoded value 0-15 (0 when not a hex digit)
//   valid   : 1 when char_in is an accepted hex digit
// LOWER_HEX selects whether 'a'-'f' are accepted alongside 'A'-'F'.
module srec_hex_decode
  import srec_pkg::*;
#(
  parameter int LOWER_HEX = 1
) (
  input  logic [7:0] char_in,
  output logic [3:0] nibble,
  output logic       valid
);

  always_comb begin
    nibble = 4'd0;
    valid  = 1'b0;
    if (char_in >= CH_0 && char_in <= CH_9) begin
      nibble = char_in[3:0];
      valid  = 1'b1;
    end else if (char_in >= CH_UP_A && char_in <= CH_UP_F) begin
      // 'A' is 0x41: low nibble 1 maps to 10
      nibble = char_in[3:0] + 4'd9;
      valid  = 1'b1;
    end else if ((LOWER_HEX != 0) && char_in >= CH_LOW_A && char_in <= CH_LOW_F) begin
      nibble = char_in[3:0] + 4'd9;
      valid  = 1'b1;
    end
  end

endmodule

// File: rtl/srec_stream_decoder.sv
// Motorola S-record stream decoder.
// Consumes one ASCII character per char_ready strobe, decodes S0-S9 records,
// issues byte writes for S1/S2/S3 data, captures the S7/S8/S9 entry point and
// reports the first fault since the last clear_error.
// Ports:
//   clock, reset_n       : clock, asynchronous active-low reset
//   char_data/char_ready : incoming character and its one-cycle strobe
//   clear_error          : clears sticky error and error_code
//   write_address/write_byte/write_enable : byte write strobe to the loader
//   entry_address/entry_valid             : entry point from last good S7-S9
//   record_ok            : pulse when a record ends with good checksum and EOL
//   error/error_code     : sticky fault flag and first fault code
module srec_stream_decoder
  import srec_pkg::*;
#(
  parameter int ADDR_W    = 32,
  parameter int CSUM_EN   = 1,
  parameter int LOWER_HEX = 1
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic [7:0]        char_data,
  input  logic              char_ready,
  input  logic              clear_error,
  output logic [ADDR_W-1:0] write_address,
  output logic [7:0]        write_byte,
  output logic              write_enable,
  output logic [ADDR_W-1:0] entry_address,
  output logic              entry_valid,
  output logic              record_ok,
  output logic              error,
  output logic [2:0]        error_code
);

  state_t state_q, state_d;
  logic [7:0]        type_q, type_d;
  logic [2:0]        nbytes_q, nbytes_d;
  logic [2:0]        nib_cnt_q, nib_cnt_d;
  logic [7:0]        byte_cnt_q, byte_cnt_d;
  logic [7:0]        sum_q, sum_d;
  logic [3:0]        hi_nib_q, hi_nib_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              cr_seen_q, cr_seen_d;

  logic [ADDR_W-1:0] write_address_q, write_address_d;
  logic [7:0]        write_byte_q, write_byte_d;
  logic              write_enable_q, write_enable_d;
  logic [ADDR_W-1:0] entry_address_q, entry_address_d;
  logic              entry_valid_q, entry_valid_d;
  logic              record_ok_q, record_ok_d;
  logic              error_q, error_d;
  logic [2:0]        error_code_q, error_code_d;

  logic [3:0] nib;
  logic       nib_valid;
  logic [7:0] byte_val;
  logic [7:0] min_cnt;
  logic [7:0] csum_total;
  logic [2:0] last_nib;
  logic [2:0] type_bytes;
  logic       is_data_type;
  logic       is_entry_type;
  logic       new_err;
  logic [2:0] new_code;

  srec_hex_decode #(.LOWER_HEX(LOWER_HEX)) u_hex (
    .char_in (char_data),
    .nibble  (nib),
    .valid   (nib_valid)
  );

  assign byte_val      = {hi_nib_q, nib};
  assign min_cnt       = {5'd0, nbytes_q} + 8'd1;
  assign csum_total    = sum_q + byte_val;
  // index of the final address nibble, 2*N-1 (3-bit wrap makes N=4 give 7)
  assign last_nib      = {nbytes_q[1:0], 1'b0} - 3'd1;
  assign type_bytes    = addr_bytes(char_data);
  assign is_data_type  = (type_q == 8'h31) || (type_q == 8'h32) || (type_q == 8'h33);
  assign is_entry_type = (type_q == 8'h37) || (type_q == 8'h38) || (type_q == 8'h39);

  always_comb begin
    state_d         = state_q;
    type_d          = type_q;
    nbytes_d        = nbytes_q;
    nib_cnt_d       = nib_cnt_q;
    byte_cnt_d      = byte_cnt_q;
    sum_d           = sum_q;
    hi_nib_d        = hi_nib_q;
    addr_d          = addr_q;
    cr_seen_d       = cr_seen_q;
    write_address_d = write_address_q;
    write_byte_d    = write_byte_q;
    write_enable_d  = 1'b0;
    entry_address_d = entry_address_q;
    entry_valid_d   = 1'b0;
    record_ok_d     = 1'b0;
    error_d         = error_q;
    error_code_d    = error_code_q;
    new_err         = 1'b0;
    new_code        = ERR_NONE;

    if (char_ready) begin
      case (state_q)
        ST_IDLE: begin
          if (char_data == CH_S) begin
            state_d = ST_TYPE;
          end else if (char_data != CH_CR && char_data != CH_LF) begin
            new_err  = 1'b1;
            new_code = ERR_START;
          end
        end
        ST_TYPE: begin
          if (type_bytes == 3'd0) begin
            new_err  = 1'b1;
            new_code = ERR_TYPE;
          end else begin
            type_d    = char_data;
            nbytes_d  = type_bytes;
            nib_cnt_d = 3'd0;
            addr_d    = '0;
            cr_seen_d = 1'b0;
            state_d   = ST_CNT_HI;
          end
        end
        ST_CNT_HI, ST_DATA_HI, ST_CSUM_HI: begin
          if (!nib_valid) begin
            new_err  = 1'b1;
            new_code = ERR_HEX;
          end else begin
            hi_nib_d = nib;
            state_d  = (state_q == ST_CNT_HI)  ? ST_CNT_LO  :
                       (state_q == ST_DATA_HI) ? ST_DATA_LO : ST_CSUM_LO;
          end
        end
        ST_CNT_LO: begin
          if (!nib_valid) begin
            new_err  = 1'b1;
            new_code = ERR_HEX;
          end else if (byte_val < min_cnt) begin
            new_err  = 1'b1;
            new_code = ERR_LEN;
          end else begin
            // count covers address + data + checksum; keep only the data part
            byte_cnt_d = byte_val - min_cnt;
            sum_d      = byte_val;
            state_d    = ST_ADDR;
          end
        end
        ST_ADDR: begin
          if (!nib_valid) begin
            new_err  = 1'b1;
            new_code = ERR_HEX;
          end else begin
            // shifting drops MSBs when the record address is wider than ADDR_W
            addr_d = {addr_q[ADDR_W-5:0], nib};
            if (!nib_cnt_q[0]) begin
              hi_nib_d = nib;
            end else begin
              sum_d = sum_q + byte_val;
            end
            if (nib_cnt_q == last_nib) begin
              state_d = (byte_cnt_q == 8'd0) ? ST_CSUM_HI : ST_DATA_HI;
            end else begin
              nib_cnt_d = nib_cnt_q + 3'd1;
            end
          end
        end
        ST_DATA_LO: begin
          if (!nib_valid) begin
            new_err  = 1'b1;
            new_code = ERR_HEX;
          end else begin
            sum_d      = sum_q + byte_val;
            byte_cnt_d = byte_cnt_q - 8'd1;
            state_d    = (byte_cnt_q == 8'd1) ? ST_CSUM_HI : ST_DATA_HI;
            // written immediately; a later checksum fault cannot undo it
            if (is_data_type) begin
              write_enable_d  = 1'b1;
              write_address_d = addr_q;
              write_byte_d    = byte_val;
              addr_d          = addr_q + 1'b1;
            end
          end
        end
        ST_CSUM_LO: begin
          if (!nib_valid) begin
            new_err  = 1'b1;
            new_code = ERR_HEX;
          end else if ((CSUM_EN != 0) && (csum_total != 8'hFF)) begin
            new_err  = 1'b1;
            new_code = ERR_CSUM;
          end else begin
            state_d = ST_EOL;
          end
        end
        ST_EOL: begin
          if (char_data == CH_CR && !cr_seen_q) begin
            cr_seen_d = 1'b1;
          end else if (char_data == CH_LF) begin
            state_d     = ST_IDLE;
            record_ok_d = 1'b1;
            if (is_entry_type) begin
              entry_valid_d   = 1'b1;
              entry_address_d = addr_q;
            end
          end else begin
            new_err  = 1'b1;
            new_code = ERR_EOL;
          end
        end
        ST_RESYNC: begin
          if (char_data == CH_LF) begin
            state_d = ST_IDLE;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end

    // a fault in the same cycle as clear_error takes priority over the clear
    if (new_err) begin
      state_d = ST_RESYNC;
      error_d = 1'b1;
      if (!error_q || clear_error) begin
        error_code_d = new_code;
      end
    end else if (clear_error) begin
      error_d      = 1'b0;
      error_code_d = ERR_NONE;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q         <= ST_IDLE;
      type_q          <= 8'd0;
      nbytes_q        <= 3'd0;
      nib_cnt_q       <= 3'd0;
      byte_cnt_q      <= 8'd0;
      sum_q           <= 8'd0;
      hi_nib_q        <= 4'd0;
      addr_q          <= '0;
      cr_seen_q       <= 1'b0;
      write_address_q <= '0;
      write_byte_q    <= 8'd0;
      write_enable_q  <= 1'b0;
      entry_address_q <= '0;
      entry_valid_q   <= 1'b0;
      record_ok_q     <= 1'b0;
      error_q         <= 1'b0;
      error_code_q    <= ERR_NONE;
    end else begin
      state_q         <= state_d;
      type_q          <= type_d;
      nbytes_q        <= nbytes_d;
      nib_cnt_q       <= nib_cnt_d;
      byte_cnt_q      <= byte_cnt_d;
      sum_q           <= sum_d;
      hi_nib_q        <= hi_nib_d;
      addr_q          <= addr_d;
      cr_seen_q       <= cr_seen_d;
      write_address_q <= write_address_d;
      write_byte_q    <= write_byte_d;
      write_enable_q  <= write_enable_d;
      entry_address_q <= entry_address_d;
      entry_valid_q   <= entry_valid_d;
      record_ok_q     <= record_ok_d;
      error_q         <= error_d;
      error_code_q    <= error_code_d;
    end
  end

  assign write_address = write_address_q;
  assign write_byte    = write_byte_q;
  assign write_enable  = write_enable_q;
  assign entry_address = entry_address_q;
  assign entry_valid   = entry_valid_q;
  assign record_ok     = record_ok_q;
  assign error         = error_q;
  assign error_code    = error_code_q;

endmodule

// File: tb/tb_srec_stream_decoder.sv
// Bench for srec_stream_decoder: directed records plus randomized lines. A
// line-level reference model parses each line before it is sent and queues
// the expected writes / record_ok / entry / error-code events; a monitor pops
// and compares them as the DUT produces them.
module tb_srec_stream_decoder;

  localparam logic [7:0] C_CR = 8'h0D;
  localparam logic [7:0] C_LF = 8'h0A;
  localparam logic [7:0] C_S  = 8'h53;
  localparam int K_WR = 0, K_OK = 1, K_ENT = 2, K_ERR = 3;

  typedef logic [7:0] bq_t[$];
  typedef struct {
    int          kind;
    logic [31:0] addr;
    logic [7:0]  data;
  } ev_t;

  logic        clock, reset_n, char_ready, clear_error;
  logic [7:0]  char_data;
  logic [31:0] write_address, entry_address;
  logic [7:0]  write_byte;
  logic        write_enable, entry_valid, record_ok, error;
  logic [2:0]  error_code;

  logic        uc_ready, uc_clear;
  logic [7:0]  uc_data;
  logic [31:0] uc_waddr, uc_eaddr;
  logic [7:0]  uc_wbyte;
  logic        uc_we, uc_ev, uc_ok, uc_err;
  logic [2:0]  uc_code;

  int checks = 0;
  int passes = 0;
  ev_t exp_q[$];
  bit m_err = 0;
  bit m_resync = 0;
  logic [2:0] prev_code = 3'd0;

  srec_stream_decoder #(.ADDR_W(32), .CSUM_EN(1), .LOWER_HEX(1)) dut (
    .clock(clock), .reset_n(reset_n), .char_data(char_data), .char_ready(char_ready),
    .clear_error(clear_error), .write_address(write_address), .write_byte(write_byte),
    .write_enable(write_enable), .entry_address(entry_address), .entry_valid(entry_valid),
    .record_ok(record_ok), .error(error), .error_code(error_code)
  );

  srec_stream_decoder #(.ADDR_W(32), .CSUM_EN(1), .LOWER_HEX(0)) dut_uc (
    .clock(clock), .reset_n(reset_n), .char_data(uc_data), .char_ready(uc_ready),
    .clear_error(uc_clear), .write_address(uc_waddr), .write_byte(uc_wbyte),
    .write_enable(uc_we), .entry_address(uc_eaddr), .entry_valid(uc_ev),
    .record_ok(uc_ok), .error(uc_err), .error_code(uc_code)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  function automatic int nbytes_of(logic [7:0] c);
    case (c)
      8'h30, 8'h31, 8'h35, 8'h39: return 2;
      8'h32, 8'h36, 8'h38:        return 3;
      8'h33, 8'h37:               return 4;
      default:                    return 0;
    endcase
  endfunction

  function automatic int hexv(logic [7:0] c);
    if (c >= 8'h30 && c <= 8'h39) return int'(c) - 48;
    if (c >= 8'h41 && c <= 8'h46) return int'(c) - 55;
    if (c >= 8'h61 && c <= 8'h66) return int'(c) - 87;
    return -1;
  endfunction

  function automatic logic [7:0] hexch(logic [3:0] v, bit lower);
    if (v < 4'd10) return 8'h30 + {4'h0, v};
    return (lower ? 8'h61 : 8'h41) + {4'h0, v} - 8'd10;
  endfunction

  function automatic bq_t str2q(string s);
    bq_t q;
    for (int i = 0; i < s.len(); i++) q.push_back(s[i]);
    return q;
  endfunction

  // Builds a well-formed record; delta offsets the checksum byte.
  function automatic bq_t build(int t, logic [31:0] addr, bq_t data, int delta, bit crlf, bit lower);
    bq_t q;
    int n;
    logic [7:0] sum, cnt, b, cs;
    n = nbytes_of(8'h30 + 8'(t));
    cnt = 8'(n + data.size() + 1);
    q.push_back(C_S);
    q.push_back(8'h30 + 8'(t));
    q.push_back(hexch(cnt[7:4], lower)); q.push_back(hexch(cnt[3:0], lower));
    sum = cnt;
    for (int i = n - 1; i >= 0; i--) begin
      b = addr[8*i +: 8];
      q.push_back(hexch(b[7:4], lower)); q.push_back(hexch(b[3:0], lower));
      sum = sum + b;
    end
    foreach (data[i]) begin
      b = data[i];
      q.push_back(hexch(b[7:4], lower)); q.push_back(hexch(b[3:0], lower));
      sum = sum + b;
    end
    cs = ~sum + 8'(delta);
    q.push_back(hexch(cs[7:4], lower)); q.push_back(hexch(cs[3:0], lower));
    if (crlf) q.push_back(C_CR);
    q.push_back(C_LF);
    return q;
  endfunction

  function automatic void push_ev(int kind, logic [31:0] addr, logic [7:0] data);
    ev_t e;
    e.kind = kind; e.addr = addr; e.data = data;
    exp_q.push_back(e);
  endfunction

  function automatic int rd_byte(bq_t ln, int p, output int bad);
    int h, l;
    bad = -1;
    h = hexv(ln[p]);
    if (h < 0) begin bad = p; return -1; end
    l = hexv(ln[p+1]);
    if (l < 0) begin bad = p + 1; return -1; end
    return h * 16 + l;
  endfunction

  // Reference model: parses one whole line (exactly one LF, at its end).
  function automatic void model_line(bq_t ln);
    int n, p, cnt, nd, b, bad, code, fpos;
    logic [7:0] t, sum;
    logic [31:0] addr;
    bit blank;
    if (m_resync) begin
      m_resync = 0;
      return;
    end
    blank = 1;
    foreach (ln[i]) if (ln[i] != C_CR && ln[i] != C_LF) blank = 0;
    if (blank) return;
    code = 0; fpos = 0; addr = 0; sum = 0; nd = 0; n = 0; t = ln[1]; p = 2;
    if (ln[0] != C_S) begin code = 1; fpos = 0; end
    else begin
      n = nbytes_of(t);
      if (n == 0) begin code = 3; fpos = 1; end
    end
    if (code == 0) begin
      cnt = rd_byte(ln, p, bad);
      if (bad >= 0) begin code = 2; fpos = bad; end
      else if (cnt < n + 1) begin code = 4; fpos = p + 1; end
      else begin sum = 8'(cnt); nd = cnt - n - 1; end
      p += 2;
    end
    for (int i = 0; i < n && code == 0; i++) begin
      b = rd_byte(ln, p, bad);
      if (bad >= 0) begin code = 2; fpos = bad; end
      else begin addr = (addr << 8) | 32'(b); sum = sum + 8'(b); p += 2; end
    end
    for (int k = 0; k < nd && code == 0; k++) begin
      b = rd_byte(ln, p, bad);
      if (bad >= 0) begin code = 2; fpos = bad; end
      else begin
        sum = sum + 8'(b);
        if (t == 8'h31 || t == 8'h32 || t == 8'h33) push_ev(K_WR, addr + 32'(k), 8'(b));
        p += 2;
      end
    end
    if (code == 0) begin
      b = rd_byte(ln, p, bad);
      if (bad >= 0) begin code = 2; fpos = bad; end
      else if (8'(sum + 8'(b)) != 8'hFF) begin code = 5; fpos = p + 1; end
      p += 2;
    end
    if (code == 0) begin
      if (ln[p] == C_CR) begin
        if (ln[p+1] != C_LF) begin code = 6; fpos = p + 1; end
      end else if (ln[p] != C_LF) begin
        code = 6; fpos = p;
      end
    end
    if (code == 0) begin
      push_ev(K_OK, 32'd0, 8'd0);
      if (t == 8'h37 || t == 8'h38 || t == 8'h39) push_ev(K_ENT, addr, 8'd0);
    end else begin
      if (!m_err) push_ev(K_ERR, 32'(code), 8'd1);
      m_err = 1;
      // a fault on the LF itself leaves the decoder waiting for the next line's LF
      if (ln[fpos] == C_LF) m_resync = 1;
    end
  endfunction

  task automatic chk(string nm, logic [31:0] act, logic [31:0] expv);
    checks++;
    if (act === expv) passes++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, expv);
  endtask

  task automatic pop_check(string nm, int kind, logic [31:0] addr, logic [7:0] data);
    ev_t e;
    checks++;
    if (exp_q.size() == 0) begin
      $display("FAIL %s: unexpected event addr=0x%0h data=0x%0h, nothing expected", nm, addr, data);
      return;
    end
    e = exp_q.pop_front();
    if (e.kind == kind && e.addr === addr && e.data === data) passes++;
    else $display("FAIL %s: got kind=%0d addr=0x%0h data=0x%0h expected kind=%0d addr=0x%0h data=0x%0h",
                  nm, kind, addr, data, e.kind, e.addr, e.data);
  endtask

  // Monitor: sample 1 time unit after each rising edge.
  always @(posedge clock) begin
    #1;
    if (write_enable) pop_check("write", K_WR, write_address, write_byte);
    if (record_ok)    pop_check("record_ok", K_OK, 32'd0, 8'd0);
    if (entry_valid)  pop_check("entry", K_ENT, entry_address, 8'd0);
    if (error_code != prev_code) begin
      pop_check("error_code", K_ERR, {29'd0, error_code}, {7'd0, error});
      prev_code = error_code;
    end
  end

  task automatic send_char(logic [7:0] c);
    char_data  = c;
    char_ready = 1'b1;
    @(negedge clock);
    char_ready = 1'b0;
    repeat ($urandom_range(0, 2)) @(negedge clock);
  endtask

  task automatic send_line(bq_t ln);
    model_line(ln);
    foreach (ln[i]) send_char(ln[i]);
  endtask

  task automatic do_clear();
    if (m_err) push_ev(K_ERR, 32'd0, 8'd0);
    m_err = 0;
    clear_error = 1'b1;
    @(negedge clock);
    clear_error = 1'b0;
  endtask

  initial begin
    bq_t d, ln;
    bq_t tail;
    int types[9] = '{0, 1, 2, 3, 5, 6, 7, 8, 9};
    logic [7:0] badc[5] = '{8'h47, 8'h78, 8'h0D, 8'h20, 8'h53};
    int t, nd, sel, pos;

    reset_n = 1'b0; char_ready = 1'b0; char_data = 8'd0; clear_error = 1'b0;
    uc_ready = 1'b0; uc_data = 8'd0; uc_clear = 1'b0;
    repeat (3) @(negedge clock);
    reset_n = 1'b1;
    @(negedge clock);
    chk("reset_write_enable", {31'd0, write_enable}, 32'd0);
    chk("reset_write_address", write_address, 32'd0);
    chk("reset_error", {31'd0, error}, 32'd0);
    chk("reset_error_code", {29'd0, error_code}, 32'd0);
    chk("reset_entry", {entry_address[30:0], entry_valid}, 32'd0);

    // 16 writes 00..0F at 0x0000.., CRLF
    d.delete();
    for (int i = 0; i < 16; i++) d.push_back(8'(i));
    send_line(build(1, 32'h0, d, 0, 1, 0));
    // S3 at 0x1000, LF only
    d.delete(); d.push_back(8'hAA); d.push_back(8'hBB); d.push_back(8'hCC); d.push_back(8'hDD);
    send_line(build(3, 32'h1000, d, 0, 0, 0));
    repeat (3) @(negedge clock);
    chk("good_error", {31'd0, error}, 32'd0);

    // checksum off by one, then a good record with error still set
    d.delete(); d.push_back(8'h11); d.push_back(8'h22); d.push_back(8'h33);
    send_line(build(1, 32'h0200, d, 1, 1, 0));
    d.delete(); d.push_back(8'h44); d.push_back(8'h55);
    send_line(build(1, 32'h0300, d, 0, 1, 0));
    repeat (3) @(negedge clock);
    chk("csum_error", {31'd0, error}, 32'd1);
    chk("csum_code", {29'd0, error_code}, 32'd5);

    do_clear();
    send_line(str2q("S1G3000001FB\n"));
    send_line(build(1, 32'h0400, d, 0, 0, 0));
    repeat (3) @(negedge clock);
    chk("hex_code", {29'd0, error_code}, 32'd2);
    do_clear();
    repeat (2) @(negedge clock);
    chk("clear_error", {31'd0, error}, 32'd0);
    chk("clear_code", {29'd0, error_code}, 32'd0);

    send_line(str2q("S5030001FB\r\n"));
    send_line(str2q("S9030100FB\r\n"));
    repeat (3) @(negedge clock);
    chk("entry_address", entry_address, 32'h0100);

    // reset in the middle of data: two writes complete, third byte half-received
    push_ev(K_WR, 32'h0, 8'h11);
    push_ev(K_WR, 32'h1, 8'h22);
    tail = str2q("S107000011223");
    foreach (tail[i]) send_char(tail[i]);
    repeat (2) @(negedge clock);
    reset_n = 1'b0;
    #1;
    chk("rst_mid_we", {31'd0, write_enable}, 32'd0);
    chk("rst_mid_waddr", write_address, 32'd0);
    chk("rst_mid_wbyte", {24'd0, write_byte}, 32'd0);
    chk("rst_mid_ok", {30'd0, record_ok, entry_valid}, 32'd0);
    chk("rst_mid_entry", entry_address, 32'd0);
    chk("rst_mid_pending", 32'(exp_q.size()), 32'd0);
    @(negedge clock);
    reset_n = 1'b1;
    m_err = 0; m_resync = 0;
    @(negedge clock);
    d.delete(); d.push_back(8'h77);
    send_line(build(2, 32'h00ABCDEF, d, 0, 1, 0));

    send_line(str2q("S4030000FC\n"));
    repeat (3) @(negedge clock);
    chk("type_code", {29'd0, error_code}, 32'd3);
    do_clear();
    send_line(str2q("S1020000\n"));
    repeat (3) @(negedge clock);
    chk("len_code", {29'd0, error_code}, 32'd4);
    do_clear();

    // lowercase hex rejected by the LOWER_HEX=0 instance
    tail = str2q("S10a");
    foreach (tail[i]) begin
      uc_data = tail[i]; uc_ready = 1'b1;
      @(negedge clock);
      uc_ready = 1'b0;
    end
    @(negedge clock);
    chk("uc_lower_error", {31'd0, uc_err}, 32'd1);
    chk("uc_lower_code", {29'd0, uc_code}, 32'd2);

    for (int li = 0; li < 200; li++) begin
      t = types[$urandom_range(0, 8)];
      nd = (t >= 7) ? 0 : int'($urandom_range(0, 8));
      d.delete();
      for (int k = 0; k < nd; k++) d.push_back(8'($urandom));
      sel = $urandom_range(0, 11);
      ln = build(t, $urandom, d, (sel == 2) ? int'($urandom_range(1, 255)) : 0,
                 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      case (sel)
        0: begin
          pos = $urandom_range(1, ln.size() - 2);
          ln[pos] = badc[$urandom_range(0, 4)];
        end
        1: begin
          pos = $urandom_range(1, ln.size() - 2);
          while (ln.size() > pos) void'(ln.pop_back());
          ln.push_back(C_LF);
        end
        3: ln[0] = 8'h58;
        4: ln.insert(ln.size() - 1, C_CR);
        5: ln[1] = 8'h34;
        6: begin
          ln.delete();
          if ($urandom_range(0, 1) == 1) ln.push_back(C_CR);
          ln.push_back(C_LF);
        end
        default: ;
      endcase
      send_line(ln);
      if ($urandom_range(0, 3) == 0) do_clear();
    end

    repeat (5) @(negedge clock);
    chk("final_pending", 32'(exp_q.size()), 32'd0);
    chk("final_error", {31'd0, error}, {31'd0, m_err});
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
